// File: rtl/desmapeamento.sv
// rtl/desmapeamento.sv - seven-segment pattern decoder with stability filter and error count
module desmapeamento #(
  parameter int ESTAVEL = 3
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [6:0] Segmentos,
  input  logic       Amostra,
  output logic [4:0] Linha,
  output logic       Validade,
  output logic       Erro,
  output logic       Ambiguo,
  output logic       Pronto,
  output logic [7:0] ContErros
);

  typedef enum logic [1:0] {VAZIO, CONTANDO, TRAVADO} estado_t;

  localparam logic [3:0] EST4 = 4'(ESTAVEL);

  estado_t    estado;
  logic [6:0] candidato;
  logic [3:0] contagem;

  logic [4:0] d_linha;
  logic       d_val;
  logic       d_err;
  logic       d_amb;
  logic       igual;
  logic       chega;
  logic       commit;

  // Decode is taken from the live input: on every commit edge it equals the candidate.
  always_comb begin
    d_linha = 5'd0;
    d_val   = 1'b1;
    d_err   = 1'b0;
    d_amb   = 1'b0;
    case (Segmentos)
      7'b1011011: d_linha = 5'd0;
      7'b0011111: d_linha = 5'd1;
      7'b0110011: d_linha = 5'd2;
      7'b0111011: d_linha = 5'd3;
      7'b1110000: d_linha = 5'd4;
      7'b1110111: d_linha = 5'd5;
      7'b0010101: d_linha = 5'd6;
      7'b0101010: d_linha = 5'd7;
      7'b0110111: begin d_linha = 5'd8; d_amb = 1'b1; end
      7'b1111011: d_linha = 5'd9;
      7'b0011100: d_linha = 5'd10;
      7'b0111100: d_linha = 5'd11;
      7'b0001111: d_linha = 5'd12;
      7'b1100111: d_linha = 5'd15;
      7'b1000111: d_linha = 5'd16;
      7'b0111101: d_linha = 5'd17;
      7'b1001110: d_linha = 5'd18;
      7'b1110011: d_linha = 5'd19;
      7'b1101111: d_val = 1'b0;
      default: begin d_val = 1'b0; d_err = 1'b1; end
    endcase
  end

  always_comb begin
    igual  = (Segmentos == candidato);
    chega  = ((contagem + 4'd1) == EST4);
    commit = 1'b0;
    if (Amostra) begin
      case (estado)
        VAZIO:    commit = (EST4 == 4'd1);
        CONTANDO: commit = igual ? chega : (EST4 == 4'd1);
        TRAVADO:  commit = !igual && (EST4 == 4'd1);
        default:  commit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      estado    <= VAZIO;
      candidato <= 7'd0;
      contagem  <= 4'd0;
      Linha     <= 5'd0;
      Validade  <= 1'b0;
      Erro      <= 1'b0;
      Ambiguo   <= 1'b0;
      Pronto    <= 1'b0;
      ContErros <= 8'd0;
    end else begin
      Pronto <= 1'b0;
      if (Amostra) begin
        if (estado == CONTANDO && igual) begin
          contagem <= contagem + 4'd1;
          if (chega) estado <= TRAVADO;
        end else if (estado == VAZIO || !igual) begin
          // New candidate restarts the run, from any state.
          candidato <= Segmentos;
          contagem  <= 4'd1;
          estado    <= (EST4 == 4'd1) ? TRAVADO : CONTANDO;
        end
      end
      if (commit) begin
        Linha    <= d_linha;
        Validade <= d_val;
        Erro     <= d_err;
        Ambiguo  <= d_amb;
        Pronto   <= 1'b1;
        if (d_err && ContErros != 8'hFF) ContErros <= ContErros + 8'd1;
      end
    end
  end

endmodule
